// File: rtl/rx_frame_ctrl.sv
// Receive-frame sequencer: polarity-corrects symbols after boundary detection,
// captures the length header, streams the payload and re-arms the boundary detector.
// Optional trailing even-parity bit enabled by defining RX_FRAME_PARITY_EN.
module rx_frame_ctrl #(
  parameter int LEN_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     PD_flag,
  input  logic                     BD_flag,
  input  logic                     BD_sgn,
  input  logic                     BPSK,
  input  logic [TIMEOUT_WIDTH-1:0] RX_TIMEOUT,
  output logic                     disassert_BD,
  output logic [LEN_WIDTH-1:0]     HDR_LEN,
  output logic                     HDR_vld,
  output logic                     bit_out,
  output logic                     bit_vld,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0] HDR_BITS = CW'(LEN_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
`ifdef RX_FRAME_PARITY_EN
    PARITY,
`endif
    FLUSH
  } state_t;

  state_t                   state, state_n;
  logic [TIMEOUT_WIDTH-1:0] to_cnt, to_cnt_n, to_inc;
  logic [CW-1:0]            cnt, cnt_n, cnt_inc;
  // Only the first LEN_WIDTH-1 header bits need storing; the last one is shifted in on capture.
  logic [LEN_WIDTH-2:0]     hdr_sr, hdr_sr_n;
  logic [LEN_WIDTH-1:0]     hdr_shift;
  logic                     cbit;
  logic                     disassert_BD_n, HDR_vld_n, bit_out_n, bit_vld_n;
  logic                     frame_done_n, frame_err_n;
  logic [LEN_WIDTH-1:0]     HDR_LEN_n;
`ifdef RX_FRAME_PARITY_EN
  logic                     par, par_n;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      cnt          <= '0;
      hdr_sr       <= '0;
      disassert_BD <= 1'b0;
      HDR_LEN      <= '0;
      HDR_vld      <= 1'b0;
      bit_out      <= 1'b0;
      bit_vld      <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
`ifdef RX_FRAME_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      to_cnt       <= to_cnt_n;
      cnt          <= cnt_n;
      hdr_sr       <= hdr_sr_n;
      disassert_BD <= disassert_BD_n;
      HDR_LEN      <= HDR_LEN_n;
      HDR_vld      <= HDR_vld_n;
      bit_out      <= bit_out_n;
      bit_vld      <= bit_vld_n;
      frame_done   <= frame_done_n;
      frame_err    <= frame_err_n;
`ifdef RX_FRAME_PARITY_EN
      par          <= par_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    to_cnt_n       = to_cnt;
    cnt_n          = cnt;
    hdr_sr_n       = hdr_sr;
    disassert_BD_n = disassert_BD;
    HDR_LEN_n      = HDR_LEN;
    bit_out_n      = bit_out;
    HDR_vld_n      = 1'b0;
    bit_vld_n      = 1'b0;
    frame_done_n   = 1'b0;
    frame_err_n    = 1'b0;
`ifdef RX_FRAME_PARITY_EN
    par_n          = par;
`endif
    cbit      = BPSK ^ ~BD_sgn;
    hdr_shift = {hdr_sr, cbit};
    cnt_inc   = cnt + CW'(1);
    to_inc    = (&to_cnt) ? to_cnt : to_cnt + TIMEOUT_WIDTH'(1);

    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (!PD_flag) begin
            to_cnt_n = '0;
          end else if (BD_flag) begin
            // Boundary wins over a coincident timeout.
            state_n     = HDR;
            hdr_sr_n    = '0;
            hdr_sr_n[0] = cbit;
            cnt_n       = CW'(1);
            to_cnt_n    = '0;
`ifdef RX_FRAME_PARITY_EN
            par_n       = cbit;
`endif
          end else if (RX_TIMEOUT != '0 && to_inc >= RX_TIMEOUT) begin
            frame_err_n    = 1'b1;
            disassert_BD_n = 1'b1;
            state_n        = FLUSH;
            to_cnt_n       = '0;
          end else begin
            to_cnt_n = to_inc;
          end
        end

        HDR: begin
          if (!PD_flag) begin
            frame_err_n    = 1'b1;
            disassert_BD_n = 1'b1;
            state_n        = FLUSH;
          end else begin
            hdr_sr_n = hdr_shift[LEN_WIDTH-2:0];
            cnt_n    = cnt_inc;
`ifdef RX_FRAME_PARITY_EN
            par_n    = par ^ cbit;
`endif
            if (cnt_inc == HDR_BITS) begin
              HDR_LEN_n = hdr_shift;
              HDR_vld_n = 1'b1;
              cnt_n     = '0;
              if (hdr_shift == '0) begin
`ifdef RX_FRAME_PARITY_EN
                state_n        = PARITY;
`else
                frame_done_n   = 1'b1;
                disassert_BD_n = 1'b1;
                state_n        = FLUSH;
`endif
              end else begin
                state_n = PAYLOAD;
              end
            end
          end
        end

        PAYLOAD: begin
          if (!PD_flag) begin
            frame_err_n    = 1'b1;
            disassert_BD_n = 1'b1;
            state_n        = FLUSH;
          end else begin
            bit_out_n = cbit;
            bit_vld_n = 1'b1;
            cnt_n     = cnt_inc;
`ifdef RX_FRAME_PARITY_EN
            par_n     = par ^ cbit;
`endif
            if (cnt_inc == {1'b0, HDR_LEN}) begin
              cnt_n = '0;
`ifdef RX_FRAME_PARITY_EN
              state_n        = PARITY;
`else
              frame_done_n   = 1'b1;
              disassert_BD_n = 1'b1;
              state_n        = FLUSH;
`endif
            end
          end
        end

`ifdef RX_FRAME_PARITY_EN
        PARITY: begin
          if ((par ^ cbit) == 1'b0) frame_done_n = 1'b1;
          else                      frame_err_n  = 1'b1;
          disassert_BD_n = 1'b1;
          state_n        = FLUSH;
        end
`endif

        FLUSH: begin
          disassert_BD_n = 1'b0;
          state_n        = IDLE;
          cnt_n          = '0;
          to_cnt_n       = '0;
          hdr_sr_n       = '0;
`ifdef RX_FRAME_PARITY_EN
          par_n          = 1'b0;
`endif
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule
